// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALUCTRL_ADD = 3'b000;
    localparam logic [2:0] ALUCTRL_SUB = 3'b001;
    localparam logic [2:0] ALUCTRL_AND = 3'b010;
    localparam logic [2:0] ALUCTRL_OR  = 3'b011;
    localparam logic [2:0] ALUCTRL_XOR = 3'b100;
    localparam logic [2:0] ALUCTRL_SLT = 3'b101;

    localparam logic [2:0] IMMSRC_I = 3'b000;
    localparam logic [2:0] IMMSRC_S = 3'b001;
    localparam logic [2:0] IMMSRC_B = 3'b010;
    localparam logic [2:0] IMMSRC_J = 3'b011;
    localparam logic [2:0] IMMSRC_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // State-decoded control bundle, registered as a unit in the top
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu_ctrl;
        logic [2:0] imm_src;
        logic [1:0] result_src;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_retiring(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) ||
               (s == S_BRANCH) || (s == S_JAL) || (s == S_LUI);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7b5 to ALUctrl; subtract only for R-type.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       is_rtype_i,
    output logic [2:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALUCTRL_ADD;
        case (funct3_i)
            3'b000:  alu_ctrl_o = (is_rtype_i && funct7b5_i) ? ALUCTRL_SUB : ALUCTRL_ADD;
            3'b010:  alu_ctrl_o = ALUCTRL_SLT;
            3'b100:  alu_ctrl_o = ALUCTRL_XOR;
            3'b110:  alu_ctrl_o = ALUCTRL_OR;
            3'b111:  alu_ctrl_o = ALUCTRL_AND;
            default: alu_ctrl_o = ALUCTRL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencer: per-instruction FSM sharing one memory port
// between fetch and load/store, with memory-wait timeout and retire counter.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             EQ,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             adr_src,
    output logic             pc_write,
    output logic             ir_write,
    output logic             RegWrite,
    output logic [1:0]       ALUsrcA,
    output logic [1:0]       ALUsrcB,
    output logic [2:0]       ALUctrl,
    output logic [2:0]       ImmSrc,
    output logic [1:0]       result_src,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    state_t             state_q, state_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [2:0]         alu_dec;
    logic               is_rtype, mem_done, timeout, branch_ok, branch_taken;

    assign is_rtype = (state_d == S_EXECR);

    alu_decoder u_alu_decoder (
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .is_rtype_i (is_rtype),
        .alu_ctrl_o (alu_dec)
    );

    // An ack only counts while a request is actually outstanding
    assign mem_done     = ctrl_q.mem_req && mem_ack;
    assign timeout      = (WAIT_MAX != 0) && ctrl_q.mem_req && !mem_ack &&
                          (wait_q == WAIT_W'(WAIT_MAX - 1));
    assign branch_ok    = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign branch_taken = (funct3 == 3'b000) ? EQ : (funct3 == 3'b001) ? !EQ : 1'b0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (timeout) state_d = S_TRAP; else if (mem_done) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (timeout) state_d = S_TRAP; else if (mem_done) state_d = S_MEMWB;
            S_MEMWR:  if (timeout) state_d = S_TRAP; else if (mem_done) state_d = S_FETCH;
            S_EXECR, S_EXECI: state_d = S_ALUWB;
            S_BRANCH: state_d = branch_ok ? S_FETCH : S_TRAP;
            S_MEMWB, S_ALUWB, S_JAL, S_LUI: state_d = S_FETCH;
            default:  state_d = S_TRAP;
        endcase
    end

    // Moore outputs decoded from the next state so they register alongside it
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH:  begin ctrl_d.mem_req = 1'b1; ctrl_d.src_b = SRCB_FOUR; end
            S_DECODE: begin
                ctrl_d.src_a   = SRCA_OLDPC;
                ctrl_d.src_b   = SRCB_IMM;
                ctrl_d.imm_src = IMMSRC_B;
            end
            S_MEMADR: begin
                ctrl_d.src_a   = SRCA_RS1;
                ctrl_d.src_b   = SRCB_IMM;
                ctrl_d.imm_src = (opcode == OP_LOAD) ? IMMSRC_I : IMMSRC_S;
            end
            S_MEMRD:  begin ctrl_d.mem_req = 1'b1; ctrl_d.adr_src = 1'b1; end
            S_MEMWB:  begin ctrl_d.reg_write = 1'b1; ctrl_d.result_src = RES_MEM; end
            S_MEMWR:  begin
                ctrl_d.mem_req = 1'b1;
                ctrl_d.mem_we  = 1'b1;
                ctrl_d.adr_src = 1'b1;
            end
            S_EXECR:  begin
                ctrl_d.src_a    = SRCA_RS1;
                ctrl_d.src_b    = SRCB_RS2;
                ctrl_d.alu_ctrl = alu_dec;
            end
            S_EXECI:  begin
                ctrl_d.src_a    = SRCA_RS1;
                ctrl_d.src_b    = SRCB_IMM;
                ctrl_d.imm_src  = IMMSRC_I;
                ctrl_d.alu_ctrl = alu_dec;
            end
            S_ALUWB:  begin ctrl_d.reg_write = 1'b1; ctrl_d.result_src = RES_ALUOUT; end
            S_BRANCH: begin
                ctrl_d.src_a    = SRCA_RS1;
                ctrl_d.src_b    = SRCB_RS2;
                ctrl_d.alu_ctrl = ALUCTRL_SUB;
            end
            S_JAL:    begin
                ctrl_d.src_a      = SRCA_OLDPC;
                ctrl_d.src_b      = SRCB_FOUR;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = RES_ALU;
            end
            S_LUI:    begin
                ctrl_d.src_a      = SRCA_PC;
                ctrl_d.imm_src    = IMMSRC_U;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = RES_ALU;
            end
            S_TRAP:   ctrl_d.illegal = 1'b1;
            default:  ctrl_d = '0;
        endcase
    end

    always_comb begin
        wait_d    = (ctrl_q.mem_req && !mem_ack) ? wait_q + WAIT_W'(1) : '0;
        retired_d = retired_q;
        if (state_d == S_FETCH && is_retiring(state_q)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            ctrl_q    <= '0;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    // Fetch-ack and branch-resolve enables follow their inputs in the same cycle
    assign ir_write   = (state_q == S_FETCH) && mem_done;
    assign pc_write   = ir_write || (state_q == S_JAL) ||
                        ((state_q == S_BRANCH) && branch_taken);
    assign mem_req    = ctrl_q.mem_req;
    assign mem_we     = ctrl_q.mem_we;
    assign adr_src    = ctrl_q.adr_src;
    assign RegWrite   = ctrl_q.reg_write;
    assign ALUsrcA    = ctrl_q.src_a;
    assign ALUsrcB    = ctrl_q.src_b;
    assign ALUctrl    = ctrl_q.alu_ctrl;
    assign ImmSrc     = ctrl_q.imm_src;
    assign result_src = ctrl_q.result_src;
    assign illegal    = ctrl_q.illegal;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with hand-computed expectations.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        EQ;
    logic        mem_ack;
    logic        mem_req, mem_we, adr_src, pc_write, ir_write, RegWrite, illegal;
    logic [1:0]  ALUsrcA, ALUsrcB, result_src;
    logic [2:0]  ALUctrl, ImmSrc;
    logic [31:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32), .WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .EQ(EQ), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .adr_src(adr_src), .pc_write(pc_write), .ir_write(ir_write),
        .RegWrite(RegWrite), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
        .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .result_src(result_src),
        .illegal(illegal), .retired(retired)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven and outputs sampled mid-cycle
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic b5);
        opcode = op; funct3 = f3; funct7b5 = b5; mem_ack = 1'b1;
        #1;
        check_eq("fetch_req", 32'(mem_req), 32'd1);
        check_eq("fetch_irw", 32'(ir_write), 32'd1);
        check_eq("fetch_pcw", 32'(pc_write), 32'd1);
        check_eq("fetch_srcb", 32'(ALUsrcB), 32'd2);
        tick();
        mem_ack = 1'b0;
        #1;
    endtask

    task automatic reset_cycle();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 1'b0; EQ = 1'b0; mem_ack = 1'b0;
        #12;
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_ret", retired, 32'd0);
        check_eq("rst_ill", 32'(illegal), 32'd0);
        check_eq("rst_pcw", 32'(pc_write), 32'd0);
        rst = 1'b1;
        tick();

        // add x1,x2,x3
        fetch(7'b0110011, 3'b000, 1'b0);
        check_eq("add_dec_srca", 32'(ALUsrcA), 32'd1);
        check_eq("add_dec_imm", 32'(ImmSrc), 32'd2);
        check_eq("add_dec_pcw", 32'(pc_write), 32'd0);
        tick(); #1;
        check_eq("add_ex_alu", 32'(ALUctrl), 32'd0);
        check_eq("add_ex_srca", 32'(ALUsrcA), 32'd2);
        check_eq("add_ex_srcb", 32'(ALUsrcB), 32'd0);
        tick(); #1;
        check_eq("add_wb_rw", 32'(RegWrite), 32'd1);
        check_eq("add_wb_res", 32'(result_src), 32'd0);
        tick(); #1;
        check_eq("add_ret", retired, 32'd1);
        check_eq("add_back_req", 32'(mem_req), 32'd1);

        // sub x1,x2,x3
        fetch(7'b0110011, 3'b000, 1'b1);
        tick(); #1;
        check_eq("sub_alu", 32'(ALUctrl), 32'd1);
        tick(); tick(); #1;

        // xori with funct7b5 set must not subtract
        fetch(7'b0010011, 3'b100, 1'b1);
        tick(); #1;
        check_eq("xori_alu", 32'(ALUctrl), 32'd4);
        check_eq("xori_srcb", 32'(ALUsrcB), 32'd1);
        tick(); tick(); #1;
        check_eq("xori_ret", retired, 32'd3);

        // lw x5,8(x0), ack delayed three cycles
        fetch(7'b0000011, 3'b010, 1'b0);
        tick(); #1;
        check_eq("lw_adr_imm", 32'(ImmSrc), 32'd0);
        check_eq("lw_adr_srca", 32'(ALUsrcA), 32'd2);
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            #1;
            check_eq("lw_rd_req", 32'(mem_req), 32'd1);
            check_eq("lw_rd_adr", 32'(adr_src), 32'd1);
            check_eq("lw_rd_we", 32'(mem_we), 32'd0);
            tick();
        end
        mem_ack = 1'b0;
        #1;
        check_eq("lw_wb_rw", 32'(RegWrite), 32'd1);
        check_eq("lw_wb_res", 32'(result_src), 32'd1);
        tick(); #1;
        check_eq("lw_ret", retired, 32'd4);

        // sw: store request with write enable
        fetch(7'b0100011, 3'b010, 1'b0);
        tick(); #1;
        check_eq("sw_adr_imm", 32'(ImmSrc), 32'd1);
        tick();
        mem_ack = 1'b1;
        #1;
        check_eq("sw_we", 32'(mem_we), 32'd1);
        check_eq("sw_adr", 32'(adr_src), 32'd1);
        tick();
        mem_ack = 1'b0;
        #1;
        check_eq("sw_ret", retired, 32'd5);

        // beq taken, bne not taken, both with EQ=1
        EQ = 1'b1;
        fetch(7'b1100011, 3'b000, 1'b0);
        tick(); #1;
        check_eq("beq_pcw", 32'(pc_write), 32'd1);
        check_eq("beq_alu", 32'(ALUctrl), 32'd1);
        tick(); #1;
        check_eq("beq_ret", retired, 32'd6);
        fetch(7'b1100011, 3'b001, 1'b0);
        tick(); #1;
        check_eq("bne_pcw", 32'(pc_write), 32'd0);
        tick(); #1;
        check_eq("bne_ret", retired, 32'd7);
        check_eq("bne_fetch", 32'(mem_req), 32'd1);

        // jal
        fetch(7'b1101111, 3'b000, 1'b0);
        tick(); #1;
        check_eq("jal_pcw", 32'(pc_write), 32'd1);
        check_eq("jal_rw", 32'(RegWrite), 32'd1);
        check_eq("jal_res", 32'(result_src), 32'd2);
        tick(); #1;

        // lui
        fetch(7'b0110111, 3'b000, 1'b0);
        tick(); #1;
        check_eq("lui_imm", 32'(ImmSrc), 32'd4);
        check_eq("lui_rw", 32'(RegWrite), 32'd1);
        tick(); #1;
        check_eq("lui_ret", retired, 32'd9);

        // Reset in the middle of a load read
        fetch(7'b0000011, 3'b010, 1'b0);
        tick(); tick(); #1;
        check_eq("mid_req_before", 32'(mem_req), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("mid_req_drop", 32'(mem_req), 32'd0);
        check_eq("mid_ret_clr", retired, 32'd0);
        rst = 1'b1;
        tick(); #1;
        check_eq("mid_fetch_req", 32'(mem_req), 32'd1);
        check_eq("mid_fetch_adr", 32'(adr_src), 32'd0);
        check_eq("mid_ret", retired, 32'd0);

        // Unsupported opcode traps and stays trapped
        fetch(7'h7F, 3'b000, 1'b0);
        tick(); #1;
        check_eq("trap_ill", 32'(illegal), 32'd1);
        check_eq("trap_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check_eq("trap_sticky", 32'(illegal), 32'd1);
            check_eq("trap_noreq", 32'(mem_req), 32'd0);
            check_eq("trap_ret", retired, 32'd0);
        end
        mem_ack = 1'b0;

        // Fetch never acked: trap on the 15th wait cycle
        reset_cycle();
        for (int i = 0; i < 14; i++) tick();
        #1;
        check_eq("to_still_wait", 32'(mem_req), 32'd1);
        check_eq("to_not_yet", 32'(illegal), 32'd0);
        tick(); #1;
        check_eq("to_ill", 32'(illegal), 32'd1);
        check_eq("to_req", 32'(mem_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
